// File: rtl/id_issue_stage_pkg.sv
// id_stage_params: shared decode constants, filter states and bypass channel record for the ID stage.
package id_stage_params;
   typedef enum logic [1:0] {NORMAL, WAIT_SLOT, WAIT_TARGET} IssueFilterState;
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_LUI = 6'h0F;
   localparam logic [5:0] OP_SW = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR = 6'h08;
   // Fields are sized for the widest configuration; users zero-extend into them.
   localparam int BYPASS_MAX_ADDR_WIDTH = 8;
   localparam int BYPASS_MAX_DATA_WIDTH = 64;
   typedef struct packed {
      logic valid;
      logic [BYPASS_MAX_ADDR_WIDTH-1:0] addr;
      logic data_ready;
      logic [BYPASS_MAX_DATA_WIDTH-1:0] data;
   } BypassChannel;
   function automatic logic uses_rs(input logic [5:0] op, input logic [5:0] fn);
      return !(op == OP_LUI || op == OP_J || op == OP_JAL ||
               (op == OP_SPECIAL && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)));
   endfunction
   function automatic logic uses_rt(input logic [5:0] op);
      return op == OP_SPECIAL || op == OP_BEQ || op == OP_BNE || op == OP_SW;
   endfunction
endpackage

// File: rtl/id_issue_stage_instruction_queue.sv
// instruction_queue: circular FIFO with registered full/empty and a combinational head.
module instruction_queue #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH = 4
) (
   input logic clock,
   input logic reset,
   input logic push,
   input logic [DATA_WIDTH-1:0] push_data,
   input logic pop,
   output logic full,
   output logic empty,
   output logic [DATA_WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic do_push, do_pop;
   assign full = count_q == CW'(DEPTH);
   assign empty = count_q == '0;
   assign head = mem_q[rd_ptr_q];
   always_comb begin
      do_push = push && !full;
      do_pop = pop && !empty;
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: queued decode/issue with bypass interlock, branch resolution and PC-based wrong-path filtering.
module id_issue_stage
   import id_stage_params::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int QUEUE_DEPTH = 4,
   parameter int NUM_BYPASS = 3
) (
   input logic clock,
   input logic reset,
   input logic in_valid,
   output logic in_ready,
   input logic [DATA_WIDTH-1:0] in_pc,
   input logic [DATA_WIDTH-1:0] in_instruction,
   output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
   output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
   input logic [DATA_WIDTH-1:0] rf_rdata1,
   input logic [DATA_WIDTH-1:0] rf_rdata2,
   input logic [NUM_BYPASS-1:0] bypass_valid,
   input logic [NUM_BYPASS*REG_ADDR_WIDTH-1:0] bypass_addr,
   input logic [NUM_BYPASS-1:0] bypass_data_ready,
   input logic [NUM_BYPASS*DATA_WIDTH-1:0] bypass_data,
   output logic out_valid,
   input logic out_ready,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instruction,
   output logic [DATA_WIDTH-1:0] out_src1_value,
   output logic [DATA_WIDTH-1:0] out_src2_value,
   output logic [REG_ADDR_WIDTH-1:0] out_dest,
   output logic out_reg_write,
   output logic redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_target
);
   logic push, pop, full, empty, issue, discard, taken;
   logic [2*DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] head_pc, head_instr, pc_plus4, target;
   logic [5:0] opcode, funct;
   logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
   logic is_beq, is_bne, is_j, is_jal, is_jr;
   logic hit1, hit2, rdy1, rdy2, blocked1, blocked2;
   logic [DATA_WIDTH-1:0] fwd1, fwd2;
   BypassChannel chan [NUM_BYPASS];
   IssueFilterState state_q, state_d;
   logic [DATA_WIDTH-1:0] expected_pc_q, expected_pc_d, saved_target_q, saved_target_d;
   logic [DATA_WIDTH-1:0] redirect_target_q, redirect_target_d;
   logic redirect_valid_q, redirect_valid_d;

   instruction_queue #(.DATA_WIDTH(2*DATA_WIDTH), .DEPTH(QUEUE_DEPTH)) u_queue (
      .clock(clock), .reset(reset), .push(push), .push_data({in_pc, in_instruction}),
      .pop(pop), .full(full), .empty(empty), .head(head)
   );

   assign {head_pc, head_instr} = head;
   assign opcode = head_instr[31:26];
   assign funct = head_instr[5:0];
   assign rs = REG_ADDR_WIDTH'(head_instr[25:21]);
   assign rt = REG_ADDR_WIDTH'(head_instr[20:16]);
   assign rd = REG_ADDR_WIDTH'(head_instr[15:11]);
   assign is_beq = opcode == OP_BEQ;
   assign is_bne = opcode == OP_BNE;
   assign is_j = opcode == OP_J;
   assign is_jal = opcode == OP_JAL;
   assign is_jr = opcode == OP_SPECIAL && funct == FN_JR;
   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;
   assign in_ready = !full;
   assign push = in_valid && !full;
   assign out_pc = head_pc;
   assign out_instruction = head_instr;
   assign out_dest = is_jal ? REG_ADDR_WIDTH'(31) : (opcode == OP_SPECIAL || is_j) ? rd : rt;
   assign out_reg_write = !(is_beq || is_bne || is_j || is_jr || opcode == OP_SW);
   assign redirect_valid = redirect_valid_q;
   assign redirect_target = redirect_target_q;

   always_comb begin
      for (int i = 0; i < NUM_BYPASS; i++) begin
         chan[i].valid = bypass_valid[i];
         chan[i].addr = BYPASS_MAX_ADDR_WIDTH'(bypass_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]);
         chan[i].data_ready = bypass_data_ready[i];
         chan[i].data = BYPASS_MAX_DATA_WIDTH'(bypass_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Scan oldest to youngest so the youngest matching channel wins.
   always_comb begin
      hit1 = 1'b0;
      rdy1 = 1'b0;
      fwd1 = '0;
      hit2 = 1'b0;
      rdy2 = 1'b0;
      fwd2 = '0;
      for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
         if (chan[i].valid && chan[i].addr == BYPASS_MAX_ADDR_WIDTH'(rs)) begin
            hit1 = 1'b1;
            rdy1 = chan[i].data_ready;
            fwd1 = DATA_WIDTH'(chan[i].data);
         end
         if (chan[i].valid && chan[i].addr == BYPASS_MAX_ADDR_WIDTH'(rt)) begin
            hit2 = 1'b1;
            rdy2 = chan[i].data_ready;
            fwd2 = DATA_WIDTH'(chan[i].data);
         end
      end
      out_src1_value = rs == '0 ? '0 : hit1 ? fwd1 : rf_rdata1;
      out_src2_value = rt == '0 ? '0 : hit2 ? fwd2 : rf_rdata2;
      blocked1 = uses_rs(opcode, funct) && rs != '0 && hit1 && !rdy1;
      blocked2 = uses_rt(opcode) && rt != '0 && hit2 && !rdy2;
      discard = !empty && state_q != NORMAL && head_pc != expected_pc_q;
      out_valid = !empty && !discard && !blocked1 && !blocked2;
      issue = out_valid && out_ready;
      pop = issue || discard;
   end

   always_comb begin
      pc_plus4 = head_pc + DATA_WIDTH'(4);
      taken = (is_beq && out_src1_value == out_src2_value) ||
              (is_bne && out_src1_value != out_src2_value) || is_j || is_jal || is_jr;
      target = (is_beq || is_bne) ? pc_plus4 + {{(DATA_WIDTH-18){head_instr[15]}}, head_instr[15:0], 2'b00} :
               is_jr ? out_src1_value : {pc_plus4[DATA_WIDTH-1:28], head_instr[25:0], 2'b00};
      state_d = state_q;
      expected_pc_d = expected_pc_q;
      saved_target_d = saved_target_q;
      // A branch sitting in a delay slot is treated as a plain instruction.
      redirect_valid_d = issue && taken && state_q != WAIT_SLOT;
      redirect_target_d = redirect_valid_d ? target : redirect_target_q;
      if (issue) begin
         if (state_q == WAIT_SLOT) begin
            state_d = WAIT_TARGET;
            expected_pc_d = saved_target_q;
         end else if (taken) begin
            state_d = WAIT_SLOT;
            expected_pc_d = pc_plus4;
            saved_target_d = target;
         end else begin
            state_d = NORMAL;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= NORMAL;
         expected_pc_q <= '0;
         saved_target_q <= '0;
         redirect_valid_q <= 1'b0;
         redirect_target_q <= '0;
      end else begin
         state_q <= state_d;
         expected_pc_q <= expected_pc_d;
         saved_target_q <= saved_target_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_target_q <= redirect_target_d;
      end
   end
endmodule

// File: doc/id_issue_stage.md
# id_issue_stage

Parametrised decode/issue stage for the in-order MIPS core, the successor to the single-entry ID stage. It sits between IF and EX. It buffers fetched instructions in a small queue so that IF keeps running while EX stalls. It reads the register file, forwards from a configurable number of back-pass channels, and interlocks on operands whose producers are not yet ready. It resolves branches at issue and filters wrong-path instructions by PC, so IF needs no flush wire.

## Interface
- `DATA_WIDTH`, default 32: register and PC width.
- `REG_ADDR_WIDTH`, default 5: register index width.
- `QUEUE_DEPTH`, default 4: instruction queue entries, power of two, at least 2.
- `NUM_BYPASS`, default 3: back-pass channels; channel 0 is the youngest.

- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1, `in_ready` out 1: IF handshake.
- `in_pc`, `in_instruction` in DATA_WIDTH each: fetched PC and word.
- `rf_raddr1`, `rf_raddr2` out REG_ADDR_WIDTH: register file read addresses. They carry head rs and rt.
- `rf_rdata1`, `rf_rdata2` in DATA_WIDTH: combinational register file read data.
- `bypass_valid` in NUM_BYPASS: channel holds a register-writing instruction.
- `bypass_addr` in NUM_BYPASS×REG_ADDR_WIDTH: destination register per channel.
- `bypass_data_ready` in NUM_BYPASS: data is available this cycle. It is low for a load in EX.
- `bypass_data` in NUM_BYPASS×DATA_WIDTH: forwarded values.
- `out_valid` out 1, `out_ready` in 1: EX handshake.
- `out_pc`, `out_instruction` out DATA_WIDTH: issued PC and word.
- `out_src1_value`, `out_src2_value` out DATA_WIDTH: resolved rs and rt values.
- `out_dest` out REG_ADDR_WIDTH: write register. It is 31 for jal, rt for I-type, rd otherwise.
- `out_reg_write` out 1: instruction writes a register. It is 0 for beq, bne, j, jr, sw.
- `redirect_valid` out 1, `redirect_target` out DATA_WIDTH: one-cycle taken-branch pulse to IF.

## Operation
- **Queue.**
  - Circular FIFO. `in_ready` is `count < QUEUE_DEPTH` and is registered-state only, with no dependency on `out_ready`.
  - Push happens on `in_valid && in_ready`. Pop happens on issue or on discard. Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- **Operand usage.**
  - rs is used by everything except lui, j, jal, sll, srl, sra.
  - rt is used by R-type, beq, bne and sw.
  - Register 0 is never a hazard and always reads 0.
- **Forwarding.** For each used operand, take the lowest-index channel with `bypass_valid` set and a matching `bypass_addr`.
  - If that channel has `bypass_data_ready=1`, use its data.
  - If it has `bypass_data_ready=0`, the operand is blocked.
  - If no channel matches, use `rf_rdata`.
- **Issue.** `out_valid` requires all of:
  - queue non-empty;
  - head not being discarded;
  - no blocked operand.

  Issue is `out_valid && out_ready`. All out fields are combinational from the head and the forwarding network.
- **Branch resolution.** Evaluated at issue, using resolved operands.
  - beq, bne: taken on equal or not-equal. Target is head_pc+4+(sign-extended imm<<2).
  - j, jal: always taken. Target is {(head_pc+4)[31:28], index, 2'b0}.
  - jr: always taken. Target is src1.
  - A taken branch asserts `redirect_valid` on the next cycle, for exactly one cycle, with the registered target.
- **Filter FSM.** Registers `expected_pc` and `saved_target`.
  - NORMAL: no filtering. A taken branch issues → WAIT_SLOT, with `expected_pc` set to branch_pc+4 and `saved_target` set to the target.
  - WAIT_SLOT: a head with pc ≠ `expected_pc` is discarded. The matching head issues normally as the delay slot → WAIT_TARGET, with `expected_pc` set to `saved_target`.
  - WAIT_TARGET: a head with pc ≠ `expected_pc` is discarded. The matching head issues normally → NORMAL. If that head is itself a taken branch → WAIT_SLOT instead.
  - A branch in a delay slot is issued as a plain instruction: no redirect, no state change.
- **Discard.**
  - A discard pops one entry per cycle.
  - A discard is independent of `out_ready` and of interlocks.
  - `out_valid` is 0 during a discard.

## Timing
- **Reset values.** Queue is empty. FSM is NORMAL. `expected_pc`=0, `saved_target`=0. `in_ready`=1, `out_valid`=0, `redirect_valid`=0, `redirect_target`=0.
- **Latency.** A word pushed at cycle t can issue no earlier than t+1. A back-to-back stream sustains 1 instruction per cycle when `out_ready`=1 and there are no hazards.
- **Interlock.** Interlock holds until `bypass_data_ready` rises. Issue occurs in that same cycle, using that channel's data.
- **Redirect timing.** The redirect pulse occurs one cycle after the branch handshake.
- **Queue bounds.** A full queue holds `in_ready` low. Empty → `out_valid`=0.
- **Reset mid-operation.** Queue contents are dropped, a pending redirect is cancelled, and the FSM returns to NORMAL next cycle.

## Structure
- **Shared package `id_stage_params`.** Add:
  - `IssueFilterState` enum: NORMAL, WAIT_SLOT, WAIT_TARGET.
  - opcode and funct localparams for beq, bne, j, jal, jr.
  - `BypassChannel` struct: valid, addr, data_ready, data.
- **Sub-module `instruction_queue`.** Parametrised FIFO (DATA_WIDTH, DEPTH) with push, pop, full, empty, head outputs.
- **Top level.** Decode, forwarding priority loop and filter FSM live in `id_issue_stage`.

## Test plan
- **Fill and drain.** Push 4 words with `out_ready`=0: `in_ready` falls after the 4th. Raise `out_ready`: words issue in order, 1 per cycle, and `in_ready` rises the cycle after the first pop.
- **Forwarding priority.** Head `addu $3,$1,$2`, both channels 0 and 2 valid with addr 1, data 0x11 and 0x22, both ready: `out_src1_value`=0x11.
- **Load-use stall.** Channel 0 has addr 2 with `bypass_data_ready`=0 for 2 cycles, then rises with 0x55. Expect `out_valid`=0 for 2 cycles, then issue with `out_src2_value`=0x55. A `$0` operand never stalls.
- **Taken beq.** beq at 0x100 with equal operands and imm=4: `redirect_valid`/0x114 pulses one cycle later. Queue holds 0x104, 0x108, 0x10C, 0x114: 0x104 issues, 0x108 and 0x10C are discarded without `out_valid`, and 0x114 issues with the FSM back in NORMAL.
- **jr with delay slot arriving late.** Delay slot arrives 3 cycles after the jr issues: the FSM holds WAIT_SLOT and nothing issues until 0x104 arrives. Then the target is filtered as in the beq case.
- **Reset mid-operation.** Reset in WAIT_SLOT with 3 queued entries: next cycle the queue is empty, FSM is NORMAL, and `redirect_valid`=0.
